cpu0_debug_ocimem_ctrl: RTL
===========================

// Module: cpu0_debug_ocimem_ctrl
// PURPOSE
//  System-clock consumer of the debug slave's decoded JTAG commands (jdo + take_action_ocimem_*).
//  Owns the CPU debug RAM (monitor code/data), its JTAG-side address register and the MonDReg readback register.
//  Arbitrates JTAG accesses against CPU Avalon-MM accesses to the same RAM; MonDReg feeds back to the debug slave.
// PARAMETERS
//  ADDR_W     9      word-address width; RAM depth = 2**ADDR_W x 32b
//  ROM_WORDS  64     words [0..ROM_WORDS-1] form the protected region (used only with OCIMEM_ROM_PROTECT_EN)
// PORTS
//  clk                      in   1       system clock; all logic on rising edge
//  reset                    in   1       asynchronous, active-high
//  jdo                      in   38      JTAG command/data word, stable while any take_* pulse is high
//  take_action_ocimem_a     in   1       1-cycle pulse: load address (+ optional read)
//  take_action_ocimem_b     in   1       1-cycle pulse: write data at MonAReg, then increment
//  take_no_action_ocimem_a  in   1       1-cycle pulse: read at MonAReg, then increment
//  avs_address              in   ADDR_W  CPU word address
//  avs_read / avs_write     in   1       CPU access strobes (mutually exclusive)
//  avs_byteenable           in   4       CPU write byte lanes
//  avs_writedata            in   32      CPU write data
//  avs_readdata             out  32      CPU read data, fixed latency 1 after accepted read
//  avs_waitrequest          out  1       CPU access stalled this cycle
//  MonDReg                  out  32      last JTAG read data / last JTAG write data
//  jtag_busy                out  1       FSM not in IDLE
//  cmd_overrun              out  1       sticky: JTAG command dropped while busy; cleared by reset only
//  prot_err                 out  1       sticky: write into protected region dropped
// BEHAVIOUR
//  Reset: FSM=IDLE, MonAReg=0, MonDReg=0, avs_readdata=0, avs_waitrequest=0, cmd_overrun=0, prot_err=0. RAM not cleared.
//  jdo fields: [25:17] address (low ADDR_W bits used), [34] read-after-load, [34:3] write data (ocimem_b).
//  FSM: IDLE, JRD, JCAP, JWR.
//   IDLE + ocimem_a: MonAReg<=jdo addr; jdo[34]=1 -> JRD, else stay IDLE.
//   IDLE + no_action_ocimem_a -> JRD.   IDLE + ocimem_b -> JWR.
//   JRD: issue RAM read at MonAReg -> JCAP.   JCAP: MonDReg<=RAM data; MonAReg++ -> IDLE.
//   JWR: RAM write all 4 lanes of jdo[34:3] at MonAReg; MonDReg<=that data; MonAReg++ -> IDLE.
//   JTAG read latency: MonDReg valid 3 clk edges after pulse. Write completes in 2 edges.
//  Pulse while FSM != IDLE: dropped, cmd_overrun<=1. Multiple pulses in one cycle: priority ocimem_b > ocimem_a > no_action.
//  MonAReg increment wraps modulo 2**ADDR_W (max -> 0).
//  Arbitration: JTAG wins. avs_waitrequest = (avs_read|avs_write) & (FSM!=IDLE | any take_* pulse).
//  CPU read accepted (waitrequest=0): avs_readdata valid next cycle, held until next accepted read.
//  CPU write accepted: byte lanes per avs_byteenable, same cycle.
//  Reset mid-operation: FSM aborts to IDLE; any in-flight JTAG write not yet clocked is lost.
// CONFIGURATION
//  OCIMEM_ROM_PROTECT_EN defined: writes (JTAG or CPU) to address < ROM_WORDS are suppressed, prot_err<=1;
//   a suppressed JTAG write still loads MonDReg and increments MonAReg; a suppressed CPU write completes without stall.
//  Undefined: no protection; prot_err tied 0; ROM_WORDS unused.
// STRUCTURE
//  Package cpu0_debug_pkg: FSM state enum, jdo field bit-position constants, DATA_W=32.
//  One sub-module: cpu0_debug_ocimem_ram (single-port 32b RAM, byte-write, 1-cycle sync read).
//  Arbitration, FSM, MonAReg/MonDReg stay in this module.
// TESTING
//  ocimem_a jdo addr=0x005,[34]=1 -> 3 edges later MonDReg=RAM[5], MonAReg=6, jtag_busy low.
//  ocimem_b data=0xDEADBEEF at MonAReg=0x1FF -> RAM[0x1FF]=0xDEADBEEF, MonAReg wraps to 0.
//  CPU read addr 0x10 same cycle as no_action pulse -> avs_waitrequest=1 until IDLE; then readdata=RAM[0x10].
//  Second pulse one cycle after ocimem_a[34]=1 -> dropped, cmd_overrun=1, first read result correct.
//  Macro on, CPU write 0x12345678 to addr 3 -> RAM[3] unchanged, prot_err=1; macro off -> RAM[3]=0x12345678.
//  reset asserted during JRD -> all outputs reset values next edge, FSM IDLE, MonDReg=0.

Source files
------------

// File: rtl/cpu0_debug_pkg.sv
// Shared types and jdo field positions for the CPU debug OCI memory block.
// No logic; constants only.
// No flow control.
package cpu0_debug_pkg;

    localparam int DATA_W       = 32;
    localparam int BE_W         = DATA_W / 8;
    localparam int JDO_W        = 38;
    localparam int JDO_ADDR_LSB = 17;
    localparam int JDO_RD_BIT   = 34;
    localparam int JDO_WDAT_LSB = 3;
    localparam int JDO_WDAT_MSB = 34;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_JRD,
        ST_JCAP,
        ST_JWR
    } ocimem_state_t;

endpackage

// File: rtl/cpu0_debug_ocimem_ram.sv
// Single-port debug RAM with byte-lane writes.
// Latency: read data registered 1 clk after an enabled read; writes land on the same edge.
// Backpressure: none; the controller serialises all accesses.
module cpu0_debug_ocimem_ram
    import cpu0_debug_pkg::*;
#(
    parameter int ADDR_W = 9
) (
    input  logic              clk,
    input  logic              en,
    input  logic              we,
    input  logic [BE_W-1:0]   be,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdat,
    output logic [DATA_W-1:0] rdat
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    // Contents are intentionally not reset: monitor code survives a system reset.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                for (int i = 0; i < BE_W; i++) begin
                    if (be[i]) mem[addr][i*8 +: 8] <= wdat[i*8 +: 8];
                end
            end else begin
                rdat <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/cpu0_debug_ocimem_ctrl.sv
// JTAG command FSM + CPU/JTAG arbiter for the debug RAM; optional OCIMEM_ROM_PROTECT_EN write guard.
// Latency: JTAG read lands in MonDReg 3 edges after the pulse, JTAG write 2 edges; CPU read data 1 clk.
// Backpressure: CPU stalled via avs_waitrequest while the FSM is busy or a JTAG pulse arrives.
module cpu0_debug_ocimem_ctrl
    import cpu0_debug_pkg::*;
#(
    parameter int ADDR_W    = 9,
    parameter int ROM_WORDS = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [JDO_W-1:0]  jdo,
    input  logic              take_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    input  logic              take_no_action_ocimem_a,
    input  logic [ADDR_W-1:0] avs_address,
    input  logic              avs_read,
    input  logic              avs_write,
    input  logic [BE_W-1:0]   avs_byteenable,
    input  logic [DATA_W-1:0] avs_writedata,
    output logic [DATA_W-1:0] avs_readdata,
    output logic              avs_waitrequest,
    output logic [DATA_W-1:0] MonDReg,
    output logic              jtag_busy,
    output logic              cmd_overrun,
    output logic              prot_err
);

`ifdef OCIMEM_ROM_PROTECT_EN
    localparam bit PROT_EN = 1'b1;
`else
    localparam bit PROT_EN = 1'b0;
`endif
    localparam logic [ADDR_W-1:0] ROM_LIM = ADDR_W'(ROM_WORDS);

    ocimem_state_t     state;
    logic [ADDR_W-1:0] mon_a_reg;
    logic [DATA_W-1:0] wr_dat;
    logic [DATA_W-1:0] rd_hold;
    logic              cpu_rd_pend;
    logic              any_take;
    logic              cpu_req;
    logic              cpu_go;
    logic              j_prot;
    logic              c_prot;
    logic              ram_en;
    logic              ram_we;
    logic [BE_W-1:0]   ram_be;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdat;
    logic [DATA_W-1:0] ram_rdat;
    logic              jdo_unused;

    assign jdo_unused      = ^{jdo[JDO_W-1:JDO_WDAT_MSB+1], jdo[JDO_WDAT_LSB-1:0]};
    assign any_take        = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;
    assign cpu_req         = avs_read | avs_write;
    assign avs_waitrequest = cpu_req & ((state != ST_IDLE) | any_take);
    assign cpu_go          = cpu_req & ~avs_waitrequest;
    assign jtag_busy       = (state != ST_IDLE);
    assign j_prot          = PROT_EN && (mon_a_reg < ROM_LIM);
    assign c_prot          = PROT_EN && (avs_address < ROM_LIM);
    // The RAM output only moves on a read, so it is valid for the cycle after a CPU read.
    assign avs_readdata    = cpu_rd_pend ? ram_rdat : rd_hold;

    always_comb begin
        ram_en   = 1'b0;
        ram_we   = 1'b0;
        ram_be   = '0;
        ram_addr = mon_a_reg;
        ram_wdat = wr_dat;
        if (state == ST_JRD) begin
            ram_en = 1'b1;
        end else if (state == ST_JWR) begin
            ram_en = 1'b1;
            ram_we = 1'b1;
            ram_be = j_prot ? '0 : '1;
        end else if (cpu_go) begin
            ram_en   = 1'b1;
            ram_we   = avs_write;
            ram_addr = avs_address;
            ram_wdat = avs_writedata;
            ram_be   = (avs_write && !c_prot) ? avs_byteenable : '0;
        end
    end

    cpu0_debug_ocimem_ram #(.ADDR_W(ADDR_W)) u_ram (
        .clk  (clk),
        .en   (ram_en),
        .we   (ram_we),
        .be   (ram_be),
        .addr (ram_addr),
        .wdat (ram_wdat),
        .rdat (ram_rdat)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            mon_a_reg   <= '0;
            MonDReg     <= '0;
            wr_dat      <= '0;
            cmd_overrun <= 1'b0;
        end else begin
            if (any_take && state != ST_IDLE) cmd_overrun <= 1'b1;
            case (state)
                ST_IDLE: begin
                    // jdo is only guaranteed during the pulse, so capture write data now.
                    if (take_action_ocimem_b) begin
                        wr_dat <= jdo[JDO_WDAT_MSB:JDO_WDAT_LSB];
                        state  <= ST_JWR;
                    end else if (take_action_ocimem_a) begin
                        mon_a_reg <= jdo[JDO_ADDR_LSB +: ADDR_W];
                        if (jdo[JDO_RD_BIT]) state <= ST_JRD;
                    end else if (take_no_action_ocimem_a) begin
                        state <= ST_JRD;
                    end
                end
                ST_JRD: state <= ST_JCAP;
                ST_JCAP: begin
                    MonDReg   <= ram_rdat;
                    mon_a_reg <= mon_a_reg + 1'b1;
                    state     <= ST_IDLE;
                end
                ST_JWR: begin
                    MonDReg   <= wr_dat;
                    mon_a_reg <= mon_a_reg + 1'b1;
                    state     <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cpu_rd_pend <= 1'b0;
            rd_hold     <= '0;
        end else begin
            cpu_rd_pend <= cpu_go & avs_read;
            if (cpu_rd_pend) rd_hold <= ram_rdat;
        end
    end

`ifdef OCIMEM_ROM_PROTECT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prot_err <= 1'b0;
        end else if ((state == ST_JWR && j_prot) || (cpu_go && avs_write && c_prot)) begin
            prot_err <= 1'b1;
        end
    end
`else
    assign prot_err = 1'b0;
`endif

endmodule
